// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan receiver: glyph patterns (active-high,
// {g,f,e,d,c,b,a}), FSM encodings and small helpers.
package seg_scan_decoder_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  localparam logic [1:0] S_WAIT    = 2'd0;
  localparam logic [1:0] S_STABLE  = 2'd1;
  localparam logic [1:0] S_LATCHED = 2'd2;

  typedef struct packed {
    logic       known;
    logic       blank;
    logic [3:0] nibble;
  } glyph_dec_t;

  // Only meaningful for one-hot inputs; callers gate with $onehot.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: onehot_to_idx = 2'd1;
      4'b0100: onehot_to_idx = 2'd2;
      4'b1000: onehot_to_idx = 2'd3;
      default: onehot_to_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 7-segment pattern to nibble decoder; all-off decodes as a known
// blank digit, anything outside the glyph table is reported as unknown.
module seg7_glyph_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] i_seg,
  output glyph_dec_t o_dec
);

  always_comb begin
    o_dec = '{known: 1'b1, blank: 1'b0, nibble: 4'h0};
    case (i_seg)
      GLYPH_0:     o_dec.nibble = 4'h0;
      GLYPH_1:     o_dec.nibble = 4'h1;
      GLYPH_2:     o_dec.nibble = 4'h2;
      GLYPH_3:     o_dec.nibble = 4'h3;
      GLYPH_4:     o_dec.nibble = 4'h4;
      GLYPH_5:     o_dec.nibble = 4'h5;
      GLYPH_6:     o_dec.nibble = 4'h6;
      GLYPH_7:     o_dec.nibble = 4'h7;
      GLYPH_8:     o_dec.nibble = 4'h8;
      GLYPH_9:     o_dec.nibble = 4'h9;
      GLYPH_A:     o_dec.nibble = 4'hA;
      GLYPH_B:     o_dec.nibble = 4'hB;
      GLYPH_C:     o_dec.nibble = 4'hC;
      GLYPH_D:     o_dec.nibble = 4'hD;
      GLYPH_E:     o_dec.nibble = 4'hE;
      GLYPH_F:     o_dec.nibble = 4'hF;
      GLYPH_BLANK: o_dec.blank  = 1'b1;
      default:     o_dec.known  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 4-digit 7-segment scan: recovers the 16-bit hex
// value and per-digit blank flags, with stability filtering and loss detection.
//
// state     | meaning
// S_WAIT    | no single digit selected, waiting for a one-hot sel
// S_STABLE  | one digit selected, counting cycles of unchanged sel+seg
// S_LATCHED | slot taken for this dwell, waiting for sel to move on
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int STABLE_CNT     = 16,
  parameter int TIMEOUT_CNT    = 400_000,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sel_in,
  input  logic [6:0]  seg_in,
  output logic [15:0] data,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        glyph_err,
  output logic        lost
);

  localparam int ST_W = $clog2(STABLE_CNT);
  localparam int TO_W = $clog2(TIMEOUT_CNT);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_CNT - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CNT - 1);

  logic [3:0]      r_sel_s1, r_sel_s2, r_sel_prev;
  logic [6:0]      r_seg_s1, r_seg_s2, r_seg_prev;
  logic [1:0]      r_state;
  logic [ST_W-1:0] r_stab_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [3:0][3:0] r_sh_nib;
  logic [3:0]      r_sh_blank;
  logic [3:0]      r_mask;
  logic [15:0]     r_data;
  logic [3:0]      r_blank;
  logic            r_frame_valid, r_glyph_err, r_lost;

  logic [3:0]      w_sel;
  logic [6:0]      w_seg;
  logic            w_onehot, w_changed, w_sel_changed, w_accept;
  logic [1:0]      w_state_nx, w_slot;
  logic [ST_W-1:0] w_cnt_nx;
  glyph_dec_t      w_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_s1   <= '0;
      r_sel_s2   <= '0;
      r_seg_s1   <= '0;
      r_seg_s2   <= '0;
      r_sel_prev <= '0;
      r_seg_prev <= '0;
    end else begin
      r_sel_s1   <= sel_in;
      r_sel_s2   <= r_sel_s1;
      r_seg_s1   <= seg_in;
      r_seg_s2   <= r_seg_s1;
      r_sel_prev <= w_sel;
      r_seg_prev <= w_seg;
    end
  end

  assign w_sel         = (SEL_ACTIVE_LOW != 0) ? ~r_sel_s2 : r_sel_s2;
  assign w_seg         = (SEG_ACTIVE_LOW != 0) ? ~r_seg_s2 : r_seg_s2;
  assign w_onehot      = $onehot(w_sel);
  assign w_sel_changed = (w_sel != r_sel_prev);
  assign w_changed     = w_sel_changed || (w_seg != r_seg_prev);
  assign w_slot        = onehot_to_idx(w_sel);

  seg7_glyph_decode u_decode (
    .i_seg (w_seg),
    .o_dec (w_dec)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_stab_cnt;
    w_accept   = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (w_onehot) begin
          w_state_nx = S_STABLE;
          w_cnt_nx   = '0;
        end
      end
      S_STABLE: begin
        if (w_changed) begin
          w_cnt_nx = '0;
          if (!w_onehot) w_state_nx = S_WAIT;
        end else if (r_stab_cnt == ST_LAST) begin
          w_accept   = 1'b1;
          w_state_nx = S_LATCHED;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_stab_cnt + 1'b1;
        end
      end
      S_LATCHED: begin
        // seg-only changes here are sender transition ghosting and are ignored
        if (w_sel_changed) begin
          w_cnt_nx   = '0;
          w_state_nx = w_onehot ? S_STABLE : S_WAIT;
        end
      end
      default: begin
        w_state_nx = S_WAIT;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_WAIT;
      r_stab_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_stab_cnt <= w_cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_nib      <= '0;
      r_sh_blank    <= '0;
      r_mask        <= '0;
      r_to_cnt      <= '0;
      r_data        <= 16'h0000;
      r_blank       <= 4'hF;
      r_frame_valid <= 1'b0;
      r_glyph_err   <= 1'b0;
      r_lost        <= 1'b1;
    end else begin
      r_frame_valid <= 1'b0;
      r_glyph_err   <= 1'b0;

      if (r_mask == 4'hF) begin
        r_data        <= r_sh_nib;
        r_blank       <= r_sh_blank;
        r_frame_valid <= 1'b1;
        r_lost        <= 1'b0;
        r_mask        <= '0;
      end else if (w_accept) begin
        if (w_dec.known) begin
          r_sh_nib[w_slot]   <= w_dec.nibble;
          r_sh_blank[w_slot] <= w_dec.blank;
          r_mask[w_slot]     <= 1'b1;
        end else begin
          r_glyph_err <= 1'b1;
          r_mask      <= '0;
        end
      end else if (r_to_cnt == TO_LAST) begin
        r_lost <= 1'b1;
        r_mask <= '0;
      end

      if (w_accept && w_dec.known) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_LAST) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign data        = r_data;
  assign blank       = r_blank;
  assign frame_valid = r_frame_valid;
  assign glyph_err   = r_glyph_err;
  assign lost        = r_lost;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives scan rounds, queues the frame each
// complete round should produce and checks frames as frame_valid pulses.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel_in;
  logic [6:0]  seg_in;
  logic [15:0] data;
  logic [3:0]  blank;
  logic        frame_valid, glyph_err, lost;

  int checks = 0;
  int errors = 0;
  int n_fv = 0;
  int n_ge = 0;
  int fv0, ge0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_f;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .STABLE_CNT     (16),
    .TIMEOUT_CNT    (2000),
    .SEL_ACTIVE_LOW (1),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sel_in      (sel_in),
    .seg_in      (seg_in),
    .data        (data),
    .blank       (blank),
    .frame_valid (frame_valid),
    .glyph_err   (glyph_err),
    .lost        (lost)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (frame_valid === 1'b1) begin
        n_fv++;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_f = exp_q.pop_front();
          chk("frame_data_blank", {12'h0, data, blank}, {12'h0, exp_f});
        end
      end
      if (glyph_err === 1'b1) n_ge++;
      if (frame_valid === 1'b1 || glyph_err === 1'b1)
        chk("fv_ge_exclusive", {31'h0, frame_valid & glyph_err}, 32'd0);
    end
  end

  task automatic show(input int slot, input logic [6:0] seg, input int dwell);
    logic [3:0] oh;
    oh     = 4'b0001 << slot;
    sel_in = ~oh;
    seg_in = seg;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic scan_round(input logic [15:0] val, input logic [3:0] blk, input int dwell);
    for (int s = 3; s >= 0; s--)
      show(s, blk[s] ? 7'h00 : glyph_tab[val[4*s +: 4]], dwell);
  endtask

  task automatic round_exp(input logic [15:0] val, input logic [3:0] blk, input int dwell);
    exp_q.push_back({val, blk});
    scan_round(val, blk, dwell);
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    sel_in = 4'hF;
    seg_in = 7'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b0;
    sel_in = 4'hF;
    seg_in = 7'h00;
    #12;
    chk("rst_data", {16'h0, data}, 32'h0);
    chk("rst_blank", {28'h0, blank}, 32'hF);
    chk("rst_fv", {31'h0, frame_valid}, 32'd0);
    chk("rst_ge", {31'h0, glyph_err}, 32'd0);
    chk("rst_lost", {31'h0, lost}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // clean scan of 2580, three rounds
    for (int r = 0; r < 3; r++) round_exp(16'h2580, 4'h0, 200);
    chk("t1_pending", 32'(exp_q.size()), 32'd0);
    chk("t1_frames", 32'(n_fv), 32'd3);
    chk("t1_data", {16'h0, data}, 32'h2580);
    chk("t1_blank", {28'h0, blank}, 32'h0);
    chk("t1_lost", {31'h0, lost}, 32'd0);

    // dwell too short to accept: lost asserts after the timeout, data holds
    fv0 = n_fv; ge0 = n_ge;
    for (int r = 0; r < 25; r++)
      for (int s = 3; s >= 0; s--) show(s, glyph_tab[s + 1], 10);
    chk("t3_lost_early", {31'h0, lost}, 32'd0);
    for (int r = 0; r < 30; r++)
      for (int s = 3; s >= 0; s--) show(s, glyph_tab[s + 1], 10);
    chk("t3_lost", {31'h0, lost}, 32'd1);
    chk("t3_no_frame", 32'(n_fv - fv0), 32'd0);
    chk("t3_no_err", 32'(n_ge - ge0), 32'd0);
    chk("t3_data_hold", {16'h0, data}, 32'h2580);

    // unknown glyph in slot 2 discards the round
    do_reset();
    fv0 = n_fv; ge0 = n_ge;
    show(3, 7'h5B, 200);
    show(2, 7'h01, 200);
    show(1, 7'h7F, 200);
    show(0, 7'h3F, 200);
    chk("t2_glyph_err", 32'(n_ge - ge0), 32'd1);
    chk("t2_no_frame", 32'(n_fv - fv0), 32'd0);
    round_exp(16'h2580, 4'h0, 200);
    chk("t2_frame", 32'(n_fv - fv0), 32'd1);
    chk("t2_pending", 32'(exp_q.size()), 32'd0);

    // all-blank round, then a mixed round with one blank digit
    do_reset();
    fv0 = n_fv;
    round_exp(16'h0000, 4'hF, 200);
    chk("t4_blank_all", {28'h0, blank}, 32'hF);
    round_exp(16'hAB0D, 4'b0010, 200);
    chk("t4_frames", 32'(n_fv - fv0), 32'd2);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);
    chk("t4_blank_mix", {28'h0, blank}, 32'h2);

    // non-one-hot selects are never accepted; seg glitch restarts stability
    fv0 = n_fv; ge0 = n_ge;
    sel_in = 4'b0011; seg_in = 7'h06;
    repeat (100) @(negedge clk);
    sel_in = 4'b1111;
    repeat (100) @(negedge clk);
    chk("t5_no_frame", 32'(n_fv - fv0), 32'd0);
    exp_q.push_back({16'h2580, 4'h0});
    show(3, 7'h5B, 8);
    show(3, 7'h7F, 3);
    show(3, 7'h5B, 189);
    show(2, 7'h6D, 200);
    show(1, 7'h7F, 200);
    show(0, 7'h3F, 200);
    chk("t5_frames", 32'(n_fv - fv0), 32'd1);
    chk("t5_no_err", 32'(n_ge - ge0), 32'd0);
    chk("t5_pending", 32'(exp_q.size()), 32'd0);

    // reset after three slots; the partial frame must not leak out
    fv0 = n_fv;
    show(3, 7'h5B, 200);
    show(2, 7'h6D, 200);
    show(1, 7'h7F, 200);
    rst = 1'b0;
    #1;
    chk("t6_rst_data", {16'h0, data}, 32'h0);
    chk("t6_rst_blank", {28'h0, blank}, 32'hF);
    chk("t6_rst_lost", {31'h0, lost}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    round_exp(16'hBEEF, 4'h0, 200);
    chk("t6_frames", 32'(n_fv - fv0), 32'd1);
    chk("t6_pending", 32'(exp_q.size()), 32'd0);
    chk("t6_data", {16'h0, data}, 32'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
